// File: rtl/wt_dcache_rd_arb.sv
// Round-robin arbiter sharing the L1 dcache read port among NumPorts read requesters.
// Latency: ack and index/offset in the request cycle; tag, hit and data one cycle later.
// Backpressure: mem_gnt_i low blocks every ack and freezes the pointer; requesters keep rd_req_i up.
module wt_dcache_rd_arb #(
    parameter int unsigned NumPorts = 3,
    parameter int unsigned TagW     = 28,
    parameter int unsigned IdxW     = 8,
    parameter int unsigned OffW     = 4,
    parameter int unsigned Ways     = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic [NumPorts-1:0]            rd_req_i,
    input  logic [NumPorts-1:0][TagW-1:0]  rd_tag_i,
    input  logic [NumPorts-1:0][IdxW-1:0]  rd_idx_i,
    input  logic [NumPorts-1:0][OffW-1:0]  rd_off_i,
    input  logic [NumPorts-1:0]            rd_tag_only_i,
    output logic [NumPorts-1:0]            rd_ack_o,
    output logic [NumPorts-1:0]            rd_resp_vld_o,
    output logic [63:0]                    rd_data_o,
    output logic [Ways-1:0]                rd_vld_bits_o,
    output logic [NumPorts-1:0][Ways-1:0]  rd_hit_oh_o,
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [IdxW-1:0]                mem_idx_o,
    output logic [OffW-1:0]                mem_off_o,
    output logic                           mem_tag_only_o,
    output logic [TagW-1:0]                mem_tag_o,
    input  logic [63:0]                    mem_data_i,
    input  logic [Ways-1:0]                mem_vld_bits_i,
    input  logic [Ways-1:0]                mem_hit_oh_i
);

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PtrW-1:0] rr_ptr_q;
    logic [PtrW-1:0] port_q;
    logic            resp_q;
    logic [PtrW-1:0] winner;
    logic [PtrW-1:0] winner_nxt;
    logic [PtrW:0]   cand;
    logic            found;
    logic            live;
    logic            grant;

    // A reset or clear in progress suppresses grants and drops the pending response.
    assign live  = rst_ni & ~clr_i;
    assign grant = mem_gnt_i & found & live;

    // Pick the first requesting port at or after the round-robin pointer, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
            if (cand >= (PtrW+1)'(NumPorts)) begin
                cand = cand - (PtrW+1)'(NumPorts);
            end
            if (!found && rd_req_i[cand[PtrW-1:0]]) begin
                found  = 1'b1;
                winner = cand[PtrW-1:0];
            end
        end
    end

    // Port after the winner; with a single port this is always 0.
    assign winner_nxt = (winner == PtrW'(NumPorts - 1)) ? '0 : winner + 1'b1;

    // Address side goes straight to memory from the winner (port 0 when idle).
    assign mem_req_o      = |rd_req_i;
    assign mem_idx_o      = rd_idx_i[winner];
    assign mem_off_o      = rd_off_i[winner];
    assign mem_tag_only_o = rd_tag_only_i[winner];

    // The tag arrives one cycle late, so it follows the registered winner.
    assign mem_tag_o = resp_q ? rd_tag_i[port_q] : rd_tag_i[0];

    // Data and valid bits are broadcast; consumers qualify them with rd_resp_vld_o.
    assign rd_data_o     = mem_data_i;
    assign rd_vld_bits_o = mem_vld_bits_i;

    // Decode grant and response strobes and route the hit vector to the responding port only.
    always_comb begin
        rd_ack_o      = '0;
        rd_resp_vld_o = '0;
        rd_hit_oh_o   = '0;
        if (grant) begin
            rd_ack_o[winner] = 1'b1;
        end
        if (resp_q && live) begin
            rd_resp_vld_o[port_q] = 1'b1;
            rd_hit_oh_o[port_q]   = mem_hit_oh_i;
        end
    end

    // Remember who won and advance the pointer past them; hold the pointer when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            port_q   <= '0;
            resp_q   <= 1'b0;
        end else if (clr_i) begin
            rr_ptr_q <= '0;
            port_q   <= '0;
            resp_q   <= 1'b0;
        end else if (mem_gnt_i && found) begin
            rr_ptr_q <= winner_nxt;
            port_q   <= winner;
            resp_q   <= 1'b1;
        end else begin
            resp_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Randomized and directed bench for wt_dcache_rd_arb with a queue-based scoreboard.
// Expected acks/responses are pushed by the driver and popped by a negedge monitor.
// The reference arbitration picks the requester with smallest cyclic distance from the pointer.
module tb_wt_dcache_rd_arb;

    localparam int N  = 3;
    localparam int TW = 8;
    localparam int IW = 6;
    localparam int OW = 4;
    localparam int WY = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   clr_i = 1'b0;
    logic [N-1:0]           rd_req_i = '0;
    logic [N-1:0][TW-1:0]   rd_tag_i = '0;
    logic [N-1:0][IW-1:0]   rd_idx_i = '0;
    logic [N-1:0][OW-1:0]   rd_off_i = '0;
    logic [N-1:0]           rd_tag_only_i = '0;
    logic [N-1:0]           rd_ack_o;
    logic [N-1:0]           rd_resp_vld_o;
    logic [63:0]            rd_data_o;
    logic [WY-1:0]          rd_vld_bits_o;
    logic [N-1:0][WY-1:0]   rd_hit_oh_o;
    logic                   mem_req_o;
    logic                   mem_gnt_i = 1'b0;
    logic [IW-1:0]          mem_idx_o;
    logic [OW-1:0]          mem_off_o;
    logic                   mem_tag_only_o;
    logic [TW-1:0]          mem_tag_o;
    logic [63:0]            mem_data_i = '0;
    logic [WY-1:0]          mem_vld_bits_i = '0;
    logic [WY-1:0]          mem_hit_oh_i = '0;

    wt_dcache_rd_arb #(
        .NumPorts(N), .TagW(TW), .IdxW(IW), .OffW(OW), .Ways(WY)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .rd_req_i(rd_req_i), .rd_tag_i(rd_tag_i), .rd_idx_i(rd_idx_i),
        .rd_off_i(rd_off_i), .rd_tag_only_i(rd_tag_only_i),
        .rd_ack_o(rd_ack_o), .rd_resp_vld_o(rd_resp_vld_o),
        .rd_data_o(rd_data_o), .rd_vld_bits_o(rd_vld_bits_o),
        .rd_hit_oh_o(rd_hit_oh_o), .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i), .mem_idx_o(mem_idx_o), .mem_off_o(mem_off_o),
        .mem_tag_only_o(mem_tag_only_o), .mem_tag_o(mem_tag_o),
        .mem_data_i(mem_data_i), .mem_vld_bits_i(mem_vld_bits_i),
        .mem_hit_oh_i(mem_hit_oh_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0]  ack;
        logic [IW-1:0] idx;
        logic [OW-1:0] off;
        logic          tonly;
    } ack_t;

    typedef struct {
        logic [N-1:0]         vld;
        logic [TW-1:0]        tag;
        logic [N-1:0][WY-1:0] hit;
        logic [63:0]          data;
        logic [WY-1:0]        vb;
    } rsp_t;

    ack_t ackq[$];
    rsp_t rspq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: pointer, last winner, and whether a response is owed next cycle.
    int   m_ptr  = 0;
    int   m_port = 0;
    bit   m_pend = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the DUT owes for it.
    task automatic cycle(input logic [N-1:0] req, input logic gnt, input logic [N-1:0] tonly,
                         input logic clr, input logic rst);
        int   best;
        int   bestd;
        ack_t a;
        rsp_t r;
        @(posedge clk_i);
        #1;
        rd_req_i       = req;
        mem_gnt_i      = gnt;
        rd_tag_only_i  = tonly;
        clr_i          = clr;
        rst_ni         = ~rst;
        for (int p = 0; p < N; p++) begin
            rd_tag_i[p] = TW'($urandom);
            rd_idx_i[p] = IW'($urandom);
            rd_off_i[p] = OW'($urandom);
        end
        mem_data_i     = {$urandom, $urandom};
        mem_vld_bits_i = WY'($urandom);
        mem_hit_oh_i   = WY'($urandom);

        // Response owed for last cycle's grant, unless reset/clear kills it now.
        if (m_pend && !clr && !rst) begin
            r.vld = '0;
            r.vld[m_port] = 1'b1;
            r.tag  = rd_tag_i[m_port];
            r.hit  = '0;
            r.hit[m_port] = mem_hit_oh_i;
            r.data = mem_data_i;
            r.vb   = mem_vld_bits_i;
            rspq.push_back(r);
        end

        if (clr || rst) begin
            m_ptr  = 0;
            m_port = 0;
            m_pend = 1'b0;
        end else begin
            best  = -1;
            bestd = N;
            for (int p = 0; p < N; p++) begin
                if (req[p] && ((p - m_ptr + N) % N) < bestd) begin
                    bestd = (p - m_ptr + N) % N;
                    best  = p;
                end
            end
            if (best >= 0 && gnt) begin
                a.ack = '0;
                a.ack[best] = 1'b1;
                a.idx   = rd_idx_i[best];
                a.off   = rd_off_i[best];
                a.tonly = tonly[best];
                ackq.push_back(a);
                m_port = best;
                m_ptr  = (best + 1) % N;
                m_pend = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk_i) begin
        ack_t a;
        rsp_t r;
        chk("mem_req", 128'(mem_req_o), 128'(|rd_req_i));
        if (rd_ack_o !== '0) begin
            if (ackq.size() == 0) begin
                chk("ack_unexpected", 128'(rd_ack_o), 128'(0));
            end else begin
                a = ackq.pop_front();
                chk("ack_vec", 128'(rd_ack_o), 128'(a.ack));
                chk("mem_idx", 128'(mem_idx_o), 128'(a.idx));
                chk("mem_off", 128'(mem_off_o), 128'(a.off));
                chk("mem_tag_only", 128'(mem_tag_only_o), 128'(a.tonly));
            end
        end
        if (rd_resp_vld_o !== '0 || rd_hit_oh_o !== '0) begin
            if (rspq.size() == 0) begin
                chk("rsp_unexpected", 128'(rd_resp_vld_o), 128'(0));
            end else begin
                r = rspq.pop_front();
                chk("rsp_vld", 128'(rd_resp_vld_o), 128'(r.vld));
                chk("mem_tag", 128'(mem_tag_o), 128'(r.tag));
                chk("hit_oh", 128'(rd_hit_oh_o), 128'(r.hit));
                chk("rd_data", 128'(rd_data_o), 128'(r.data));
                chk("vld_bits", 128'(rd_vld_bits_o), 128'(r.vb));
            end
        end
    end

    initial begin
        // Reset with everyone requesting: no acks or responses may appear.
        cycle(3'b111, 1'b1, 3'b000, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("rst_ack", 128'(rd_ack_o), 128'(0));
        chk("rst_resp", 128'(rd_resp_vld_o), 128'(0));
        chk("rst_hit", 128'(rd_hit_oh_o), 128'(0));

        // Single request from port 1, then its response.
        cycle(3'b010, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 3'b000, 1'b0, 1'b0);

        // Clear, then all ports continuously: 0,1,2,0,1,2.
        cycle(3'b000, 1'b1, 3'b000, 1'b1, 1'b0);
        repeat (6) cycle(3'b111, 1'b1, 3'b000, 1'b0, 1'b0);

        // Pointer to 1, then ports 0 and 2: port 2 wins, then wrap to port 0.
        cycle(3'b001, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle(3'b101, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle(3'b101, 1'b1, 3'b000, 1'b0, 1'b0);

        // Pointer to 2, memory busy 3 cycles, then port 0 wins first.
        cycle(3'b010, 1'b1, 3'b000, 1'b0, 1'b0);
        repeat (3) cycle(3'b011, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle(3'b011, 1'b1, 3'b000, 1'b0, 1'b0);

        // Grant to port 2, reset in its response cycle, then port 0 wins from pointer 0.
        cycle(3'b100, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 3'b000, 1'b0, 1'b1);
        cycle(3'b111, 1'b1, 3'b000, 1'b0, 1'b0);
        // Same with clear.
        cycle(3'b100, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle(3'b111, 1'b1, 3'b000, 1'b1, 1'b0);
        cycle(3'b111, 1'b1, 3'b000, 1'b0, 1'b0);

        // Tag-only from port 1, then port 0 (not tag-only) wins.
        cycle(3'b001, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle(3'b011, 1'b1, 3'b010, 1'b0, 1'b0);
        cycle(3'b011, 1'b1, 3'b010, 1'b0, 1'b0);

        // Randomized traffic with occasional stalls, clears and resets.
        for (int c = 0; c < 2000; c++) begin
            cycle(N'($urandom), ($urandom_range(0, 3) != 0), N'($urandom),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) == 0));
        end

        // Drain and confirm every expectation was consumed.
        cycle(3'b000, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 3'b000, 1'b0, 1'b0);
        @(negedge clk_i);
        #1;
        chk("ackq_left", 128'(ackq.size()), 128'(0));
        chk("rspq_left", 128'(rspq.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
